// File: rtl/reg_file_8x16_pkg.sv
// ============================================================================
// reg_file_8x16_pkg : shared register-file constants and types
// Rev 1.0
// ============================================================================
`default_nettype none

package reg_file_8x16_pkg;

    localparam int REG_ID_W = 3;
    localparam int NUM_REGS = 8;

    typedef logic [REG_ID_W-1:0] reg_id_t;

    localparam reg_id_t ZERO_REG = 3'd0;

endpackage : reg_file_8x16_pkg

`default_nettype wire

// File: rtl/WriteDecoder_3_8.sv
// ============================================================================
// WriteDecoder_3_8 : 3:8 register write decoder, one-hot wordlines gated by en
// Rev 1.0
// ============================================================================
`default_nettype none

module WriteDecoder_3_8
    import reg_file_8x16_pkg::*;
(
    input  logic                en,
    input  logic [REG_ID_W-1:0] reg_id,
    output logic [NUM_REGS-1:0] wordline
);

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_wl
            assign wordline[i] = en && (reg_id == REG_ID_W'(i));
        end
    endgenerate

endmodule : WriteDecoder_3_8

`default_nettype wire

// File: rtl/reg_word.sv
// ============================================================================
// reg_word : one WIDTH-bit register with wordline write enable and sync reset
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset is tested first so an unknown enable cannot disturb a reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule : reg_word

`default_nettype wire

// File: rtl/reg_file_8x16.sv
// ============================================================================
// reg_file_8x16 : 8-entry register file, 2 async read ports, 1 sync write port
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_file_8x16
    import reg_file_8x16_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                WriteReg,
    input  logic [REG_ID_W-1:0] DstReg,
    input  logic [WIDTH-1:0]    DstData,
    input  logic [REG_ID_W-1:0] SrcReg1,
    input  logic [REG_ID_W-1:0] SrcReg2,
    output logic [WIDTH-1:0]    SrcData1,
    output logic [WIDTH-1:0]    SrcData2
);

    logic [NUM_REGS-1:0]            wordline;
    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic                           bypass_hit1;
    logic                           bypass_hit2;
    logic                           unused_wordline0;

    WriteDecoder_3_8 u_decoder (
        .en       (WriteReg),
        .reg_id   (DstReg),
        .wordline (wordline)
    );

    // R0 has no storage; its wordline is deliberately left unconnected.
    assign unused_wordline0 = wordline[0];
    assign regs[0]          = '0;

    generate
        for (genvar i = 1; i < NUM_REGS; i++) begin : g_word
            reg_word #(
                .WIDTH (WIDTH)
            ) u_word (
                .clk (clk),
                .rst (rst),
                .we  (wordline[i]),
                .d   (DstData),
                .q   (regs[i])
            );
        end
    endgenerate

    assign bypass_hit1 = (BYPASS != 0) && WriteReg && (DstReg == SrcReg1) && !rst;
    assign bypass_hit2 = (BYPASS != 0) && WriteReg && (DstReg == SrcReg2) && !rst;

    always_comb begin
        SrcData1 = regs[SrcReg1];
        if (SrcReg1 == ZERO_REG) begin
            SrcData1 = '0;
        end else if (bypass_hit1) begin
            SrcData1 = DstData;
        end
    end

    always_comb begin
        SrcData2 = regs[SrcReg2];
        if (SrcReg2 == ZERO_REG) begin
            SrcData2 = '0;
        end else if (bypass_hit2) begin
            SrcData2 = DstData;
        end
    end

endmodule : reg_file_8x16

`default_nettype wire
